// File: rtl/mtimer_pkg.sv
// Shared definitions for the APB machine timer: register word indices,
// CTRL/STATUS field positions and the byte-strobe merge helper.
package mtimer_pkg;

  // Word index = paddr[4:2]; indices 6 and 7 are unmapped.
  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4,
    REG_STATUS   = 3'd5
  } reg_idx_e;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_DIV_LSB     = 16;
  localparam int CTRL_DIV_MSB     = 31;
  localparam int STATUS_PEND_BIT  = 0;

  localparam logic [63:0] CMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: emits a one-cycle tick every DIV+1
// enabled cycles; disabling or an explicit clear restarts the count.
module mtimer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_mtimer.sv
// APB slave machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a
// registered level interrupt (mtime >= mtimecmp) for the interrupt controller.
module apb_mtimer
  import mtimer_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          PRESCALE_W = 16,
  parameter logic [63:0] CMP_RESET  = CMP_RESET_DEFAULT
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  output logic                  pready,
  output logic                  perr,
  output logic                  timer_irq
);

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [31:0]           hi_shadow;
  logic                  ctrl_en;
  logic [PRESCALE_W-1:0] ctrl_div;

  logic [63:0]           mtime_nxt;
  logic [63:0]           cmp_nxt;
  logic [31:0]           ctrl_word;
  logic [31:0]           ctrl_merged;
  logic [31:0]           rd_val;
  logic                  tick;

  logic     access, wr, rd, mapped, ctrl_wr;
  reg_idx_e idx;

  logic unused_addr;
  assign unused_addr = ^{paddr[ADDR_WIDTH-1:5], paddr[1:0]};

  // The pready term blocks a second access during the completion cycle.
  assign access  = psel && penable && !pready;
  assign wr      = access && pwrite;
  assign rd      = access && !pwrite;
  assign idx     = reg_idx_e'(paddr[4:2]);
  assign mapped  = (paddr[4:2] <= 3'd5);
  assign ctrl_wr = wr && (idx == REG_CTRL);

  assign ctrl_word   = {ctrl_div, 15'd0, ctrl_en};
  assign ctrl_merged = byte_merge(ctrl_word, pdata, pstb);

  mtimer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk   (pclk),
    .rst_n (presetn),
    .en    (ctrl_en),
    .clear (ctrl_wr),
    .div   (ctrl_div),
    .tick  (tick)
  );

  // Written bytes override the incremented value on a coincident tick.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    cmp_nxt   = mtimecmp;
    if (wr) begin
      case (idx)
        REG_MTIME_LO: mtime_nxt[31:0]  = byte_merge(mtime_nxt[31:0],  pdata, pstb);
        REG_MTIME_HI: mtime_nxt[63:32] = byte_merge(mtime_nxt[63:32], pdata, pstb);
        REG_CMP_LO:   cmp_nxt[31:0]    = byte_merge(mtimecmp[31:0],   pdata, pstb);
        REG_CMP_HI:   cmp_nxt[63:32]   = byte_merge(mtimecmp[63:32],  pdata, pstb);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      REG_MTIME_LO: rd_val = mtime[31:0];
      REG_MTIME_HI: rd_val = hi_shadow;
      REG_CMP_LO:   rd_val = mtimecmp[31:0];
      REG_CMP_HI:   rd_val = mtimecmp[63:32];
      REG_CTRL:     rd_val = ctrl_word;
      REG_STATUS:   rd_val[STATUS_PEND_BIT] = timer_irq;
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      mtime     <= '0;
      mtimecmp  <= CMP_RESET;
      hi_shadow <= '0;
      ctrl_en   <= 1'b0;
      ctrl_div  <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      perr      <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= cmp_nxt;
      timer_irq <= (mtime >= mtimecmp);
      pready    <= access;
      perr      <= access && !mapped;
      prdata    <= rd ? rd_val : '0;
      if (rd && idx == REG_MTIME_LO) hi_shadow <= mtime[63:32];
      if (ctrl_wr) begin
        ctrl_en  <= ctrl_merged[CTRL_EN_BIT];
        ctrl_div <= ctrl_merged[CTRL_DIV_MSB:CTRL_DIV_LSB];
      end
    end
  end

endmodule
